mem_copy_engine: RTL

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// Single-port memory copy engine: moves len words from src to dst one word per
// READ/WRITE pair, picking the copy direction so overlapping ranges copy correctly.
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          dwe,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] cnt;
    logic          desc;
    logic [DW-1:0] hold;

    // Copy backwards only when dst lies inside the source window, so no
    // source word is overwritten before it has been read.
    logic [AW-1:0] diff;
    logic [AW-1:0] last_off;
    logic          go_desc;

    assign diff     = dst - src;
    assign last_off = len - AW'(1);
    assign go_desc  = (dst != src) && (diff < len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        dwe       = 1'b0;
        addr      = '0;
        wdata     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy      = 1'b1;
                addr      = src_ptr;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                dwe       = 1'b1;
                addr      = dst_ptr;
                wdata     = hold;
                state_nxt = (cnt > AW'(1)) ? READ : DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            desc    <= 1'b0;
            hold    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        desc    <= go_desc;
                        cnt     <= len;
                        src_ptr <= go_desc ? (src + last_off) : src;
                        dst_ptr <= go_desc ? (dst + last_off) : dst;
                    end
                end
                READ: begin
                    hold <= rdata;
                end
                WRITE: begin
                    src_ptr <= desc ? (src_ptr - AW'(1)) : (src_ptr + AW'(1));
                    dst_ptr <= desc ? (dst_ptr - AW'(1)) : (dst_ptr + AW'(1));
                    cnt     <= cnt - AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
